dmr_recovery_sequencer: RTL
===========================

// Module: dmr_recovery_sequencer
// PURPOSE
//  Multi-group recovery sequencer for DMR core pairs. Latches checker errors from all groups, then
//  recovers one group at a time in order: reset, halt, register file restore from the recovery RF,
//  PC restore, resume. Sits between the DMR checkers/recovery RF and the core cluster.
//  Adds error queuing, reset stretching, halt timeout with fatal flag, PC restore, and explicit exit.
// PARAMETERS
//  NumGroups    4   number of DMR groups (>=1)
//  RFAddrWidth  6   RF write address width
//  NumRFRegs    32  registers to restore (even, <= 2**RFAddrWidth)
//  ResetCycles  2   cycles core_rstn_o is held low (>=1)
//  HaltTimeout  64  max cycles in HALT_WAIT before fatal (>=1)
// PORTS
//  clk_i          in   1                 clock
//  rst_ni         in   1                 async reset, active-low
//  error_i        in   NumGroups         OR of RF/core checker errors per group (level)
//  halted_i       in   NumGroups         core debug halted acknowledge
//  core_rstn_o    out  NumGroups         per-group core reset, active-low
//  debug_req_o    out  NumGroups         per-group debug request pulse
//  instr_lock_o   out  NumGroups         1 = block instruction fetch of group
//  recover_o      out  NumGroups         1 = group RF sourced from recovery RF
//  rf_we_o        out  NumGroups         write enable, both RF ports, selected group
//  rf_waddr_a_o   out  RFAddrWidth       port A restore address
//  rf_waddr_b_o   out  RFAddrWidth       port B restore address
//  pc_restore_o   out  NumGroups         one-cycle PC reload strobe
//  busy_o         out  1                 1 = not in IDLE
//  group_o        out  $clog2(NumGroups) group under recovery (1 bit min)
//  fatal_o        out  1                 sticky: halt timeout occurred
// BEHAVIOUR
//  - Reset: all outputs 0 except core_rstn_o='1; state IDLE; pending, counters, fatal cleared.
//  - pending_q[i] set when error_i[i]=1; cleared when group i is selected. error_i of the group
//    under recovery is ignored from selection until back in IDLE.
//  - IDLE: if (pending_q|error_i)!=0, select lowest index -> group_q, go RESET next cycle.
//  - RESET: core_rstn_o[g]=0 for exactly ResetCycles cycles -> HALT_REQ.
//  - HALT_REQ: debug_req_o[g]=1 for one cycle -> HALT_WAIT.
//  - HALT_WAIT: halted_i[g]=1 -> RESTORE_RF; after HaltTimeout cycles without it -> FATAL.
//  - RESTORE_RF: NumRFRegs/2 cycles, counter k=0..; rf_we_o[g]=1, waddr_a=k, waddr_b=k+NumRFRegs/2;
//    after last k -> RESTORE_PC. Addresses are 0 whenever rf_we_o=0.
//  - RESTORE_PC: pc_restore_o[g]=1 for one cycle -> EXIT.
//  - EXIT: debug_req_o[g]=1 one cycle (resume), instr_lock and recover released -> IDLE.
//  - instr_lock_o[g]=1 from RESET entry through RESTORE_PC; recover_o[g]=1 in RESTORE_RF,RESTORE_PC.
//  - FATAL: fatal_o=1, core_rstn_o[g]=0 and instr_lock_o[g]=1 held; terminal until rst_ni.
//  - Pending errors of other groups are served back-to-back: EXIT->IDLE->RESET (one IDLE cycle).
//  - Non-selected groups never see any output change; group_o stable from RESET to EXIT.
//  - rst_ni mid-sequence: immediate return to reset values; pending errors discarded.
// TESTING
//  1 error_i[2] pulse 1 cycle, halted_i[2] 3 cycles after req -> rstn_o[2] low 2 cycles, 16 writes
//    a=0..15/b=16..31, pc_restore_o[2] once, resume req, busy_o low; total cycles match FSM.
//  2 error_i[1] and [3] same cycle -> group 1 fully recovered, then group 3; no group 0/2 activity.
//  3 halted_i never asserted -> FATAL after 64 HALT_WAIT cycles, fatal_o=1 sticky, rstn_o[g]=0.
//  4 error_i[0] held high throughout recovery of group 0 -> single recovery, then re-entry once.
//  5 rst_ni low in RESTORE_RF at k=7 -> all outputs at reset values asynchronously, IDLE after.
//  6 NumGroups=1, NumRFRegs=8 -> 4 restore cycles, addresses a=0..3 b=4..7, group_o=0.

Source files
------------

// File: rtl/dmr_recovery_sequencer.sv
// Recovery sequencer for DMR core pairs: queues checker errors and walks one group at a time
// through reset, halt, register-file restore, PC restore and resume.
module dmr_recovery_sequencer #(
    parameter int unsigned NumGroups   = 4,
    parameter int unsigned RFAddrWidth = 6,
    parameter int unsigned NumRFRegs   = 32,
    parameter int unsigned ResetCycles = 2,
    parameter int unsigned HaltTimeout = 64,
    localparam int unsigned GroupWidth = (NumGroups > 1) ? $clog2(NumGroups) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumGroups-1:0]   error_i,
    input  logic [NumGroups-1:0]   halted_i,
    output logic [NumGroups-1:0]   core_rstn_o,
    output logic [NumGroups-1:0]   debug_req_o,
    output logic [NumGroups-1:0]   instr_lock_o,
    output logic [NumGroups-1:0]   recover_o,
    output logic [NumGroups-1:0]   rf_we_o,
    output logic [RFAddrWidth-1:0] rf_waddr_a_o,
    output logic [RFAddrWidth-1:0] rf_waddr_b_o,
    output logic [NumGroups-1:0]   pc_restore_o,
    output logic                   busy_o,
    output logic [GroupWidth-1:0]  group_o,
    output logic                   fatal_o
);

    localparam int unsigned HalfRegs = NumRFRegs / 2;
    localparam int unsigned MaxRH    = (ResetCycles > HaltTimeout) ? ResetCycles : HaltTimeout;
    localparam int unsigned CntMax   = (MaxRH > HalfRegs) ? MaxRH : HalfRegs;
    localparam int unsigned CntWidth = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        HALT_REQ,
        HALT_WAIT,
        RESTORE_RF,
        RESTORE_PC,
        EXIT,
        FATAL
    } state_e;

    state_e                state_q, state_d;
    logic [GroupWidth-1:0] group_q, group_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [NumGroups-1:0]  pending_q, pending_d;

    logic [NumGroups-1:0]  group_oh;
    logic [NumGroups-1:0]  candidates;
    logic [NumGroups-1:0]  sel_oh;
    logic [GroupWidth-1:0] sel_idx;
    logic                  sel_valid;

    always_comb begin
        group_oh = '0;
        for (int unsigned i = 0; i < NumGroups; i++) begin
            group_oh[i] = (group_q == GroupWidth'(i));
        end
    end

    assign candidates = pending_q | error_i;

    // Scan from the top so the lowest pending index wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_oh    = '0;
        for (int i = NumGroups - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                sel_valid = 1'b1;
                sel_idx   = GroupWidth'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        group_d   = group_q;
        cnt_d     = cnt_q;
        // The group under recovery cannot re-queue itself until the sequence is back in IDLE.
        pending_d = pending_q | (error_i & ~group_oh);

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                pending_d = candidates;
                if (sel_valid) begin
                    group_d   = sel_idx;
                    pending_d = candidates & ~sel_oh;
                    state_d   = RESET;
                end
            end
            RESET: begin
                if (cnt_q == CntWidth'(ResetCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = HALT_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALT_REQ: begin
                cnt_d   = '0;
                state_d = HALT_WAIT;
            end
            HALT_WAIT: begin
                if (|(halted_i & group_oh)) begin
                    cnt_d   = '0;
                    state_d = RESTORE_RF;
                end else if (cnt_q == CntWidth'(HaltTimeout - 1)) begin
                    cnt_d   = '0;
                    state_d = FATAL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESTORE_RF: begin
                if (cnt_q == CntWidth'(HalfRegs - 1)) begin
                    cnt_d   = '0;
                    state_d = RESTORE_PC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESTORE_PC: state_d = EXIT;
            EXIT:       state_d = IDLE;
            FATAL:      state_d = FATAL;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            group_q   <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            group_q   <= group_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Outputs are decoded from state only and touch nothing but the selected group.
    always_comb begin
        core_rstn_o  = '1;
        debug_req_o  = '0;
        instr_lock_o = '0;
        recover_o    = '0;
        rf_we_o      = '0;
        rf_waddr_a_o = '0;
        rf_waddr_b_o = '0;
        pc_restore_o = '0;
        fatal_o      = 1'b0;

        unique case (state_q)
            RESET: begin
                core_rstn_o  = ~group_oh;
                instr_lock_o = group_oh;
            end
            HALT_REQ: begin
                debug_req_o  = group_oh;
                instr_lock_o = group_oh;
            end
            HALT_WAIT: instr_lock_o = group_oh;
            RESTORE_RF: begin
                instr_lock_o = group_oh;
                recover_o    = group_oh;
                rf_we_o      = group_oh;
                rf_waddr_a_o = RFAddrWidth'(cnt_q);
                rf_waddr_b_o = RFAddrWidth'(cnt_q) + RFAddrWidth'(HalfRegs);
            end
            RESTORE_PC: begin
                instr_lock_o = group_oh;
                recover_o    = group_oh;
                pc_restore_o = group_oh;
            end
            EXIT: debug_req_o = group_oh;
            FATAL: begin
                core_rstn_o  = ~group_oh;
                instr_lock_o = group_oh;
                fatal_o      = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign group_o = group_q;

endmodule
